// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : control_fsm
//  Description : Multi-cycle sequencer for the 8-bit datapath. Fetches
//                two-byte instructions, latches them into IR0/IR1 and issues
//                one execute step (plus a memory-read step for LOAD).
//                All control outputs are a Moore decode of the state
//                register and the instruction registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter int ILLEGAL_HALT = 0   // 1: opcodes 101..111 halt, 0: they are NOPs
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] mem_q,
  output logic       regwrite,
  output logic [2:0] wa,
  output logic [2:0] ra1,
  output logic [2:0] ra2,
  output logic [1:0] mode,
  output logic       wd_sel,
  output logic       wren,
  output logic       pc_mux,
  output logic       pc_inc,
  output logic       wr_pc,
  output logic       halted,
  output logic       instr_done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_LATCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_LATCH1 = 3'd3,
    S_EXEC   = 3'd4,
    S_MEMRD  = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] c_OP_ALU   = 3'b000;
  localparam logic [2:0] c_OP_LOAD  = 3'b001;
  localparam logic [2:0] c_OP_STORE = 3'b010;
  localparam logic [2:0] c_OP_JUMP  = 3'b011;
  localparam logic [2:0] c_OP_HALT  = 3'b100;

  state_t     state_q;
  logic [7:0] ir0_q;
  logic [7:0] ir1_q;
  logic [2:0] w_op;
  logic       w_op_halt;
  logic       w_unused_ir1;

  assign w_op = ir0_q[7:5];

  // Opcodes above HALT fold into HALT only when the parameter asks for it.
  assign w_op_halt = (w_op == c_OP_HALT) ||
                     ((ILLEGAL_HALT != 0) && (w_op > c_OP_HALT));

  // Register fields are taken straight from the instruction registers.
  assign wa    = ir0_q[4:2];
  assign mode  = ir0_q[1:0];
  assign ra1   = ir1_q[7:5];
  assign ra2   = ir1_q[4:2];
  assign state = state_q;

  // The two low bits of byte1 are reserved and carry no meaning.
  assign w_unused_ir1 = ^ir1_q[1:0];

  // State register and instruction latches; reset aborts any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH0;
      ir0_q   <= 8'h00;
      ir1_q   <= 8'h00;
    end else begin
      case (state_q)
        S_FETCH0: begin
          if (run) begin
            state_q <= S_LATCH0;
          end
        end
        S_LATCH0: begin
          ir0_q   <= mem_q;
          state_q <= S_FETCH1;
        end
        S_FETCH1: begin
          state_q <= S_LATCH1;
        end
        S_LATCH1: begin
          ir1_q   <= mem_q;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (w_op == c_OP_LOAD) begin
            state_q <= S_MEMRD;
          end else if (w_op_halt) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_FETCH0;
          end
        end
        S_MEMRD: begin
          state_q <= S_FETCH0;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH0;
        end
      endcase
    end
  end

  // Control decode from state and IR; pc_mux rests on the PC address.
  always_comb begin
    regwrite   = 1'b0;
    wd_sel     = 1'b0;
    wren       = 1'b0;
    pc_mux     = 1'b1;
    pc_inc     = 1'b0;
    wr_pc      = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_LATCH0, S_LATCH1: begin
        pc_inc = 1'b1;
      end
      S_EXEC: begin
        // Every opcode except LOAD completes in this cycle.
        instr_done = 1'b1;
        case (w_op)
          c_OP_ALU: begin
            regwrite = 1'b1;
          end
          c_OP_LOAD: begin
            pc_mux     = 1'b0;
            instr_done = 1'b0;
          end
          c_OP_STORE: begin
            pc_mux = 1'b0;
            wren   = 1'b1;
          end
          c_OP_JUMP: begin
            wr_pc = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_MEMRD: begin
        pc_mux     = 1'b0;
        regwrite   = 1'b1;
        wd_sel     = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_fsm
//  Description : Self-checking bench for control_fsm. A small datapath
//                (memory, regfile, PC, ALU) surrounds the sequencer; an
//                instruction-level reference model predicts architectural
//                state and the strobe schedule of every instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with illegal opcodes as NOP ----------------
  logic       reset, run;
  logic [7:0] mem_q;
  logic       regwrite, wd_sel, wren, pc_mux, pc_inc, wr_pc, halted, instr_done;
  logic [2:0] wa, ra1, ra2, state;
  logic [1:0] mode;

  control_fsm #(.ILLEGAL_HALT(0)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_q(mem_q),
    .regwrite(regwrite), .wa(wa), .ra1(ra1), .ra2(ra2), .mode(mode),
    .wd_sel(wd_sel), .wren(wren), .pc_mux(pc_mux), .pc_inc(pc_inc),
    .wr_pc(wr_pc), .halted(halted), .instr_done(instr_done), .state(state)
  );

  // ---------------- DUT with illegal opcodes as HALT ---------------
  logic       rst_h, run_h;
  logic [7:0] mq_h;
  logic       h_regwrite, h_wd_sel, h_wren, h_pc_mux, h_pc_inc, h_wr_pc, h_halted, h_instr_done;
  logic [2:0] h_wa, h_ra1, h_ra2, h_state;
  logic [1:0] h_mode;

  control_fsm #(.ILLEGAL_HALT(1)) dut_h (
    .clk(clk), .reset(rst_h), .run(run_h), .mem_q(mq_h),
    .regwrite(h_regwrite), .wa(h_wa), .ra1(h_ra1), .ra2(h_ra2), .mode(h_mode),
    .wd_sel(h_wd_sel), .wren(h_wren), .pc_mux(h_pc_mux), .pc_inc(h_pc_inc),
    .wr_pc(h_wr_pc), .halted(h_halted), .instr_done(h_instr_done), .state(h_state)
  );

  // ---------------- datapath environment ----------------
  logic [7:0] mem [256];
  logic [7:0] rf  [8];
  logic [7:0] pc;
  logic       pk_clr, pk_mem, pk_reg;
  logic [7:0] pk_a, pk_d;

  wire [7:0] w_rd1  = rf[ra1];
  wire [7:0] w_rd2  = rf[ra2];
  wire [7:0] w_addr = pc_mux ? pc : w_rd2;

  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_q <= mem[w_addr];
    if (pk_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      for (int i = 0; i < 8; i++)   rf[i]  <= 8'h00;
    end else begin
      if (pk_mem)    mem[pk_a] <= pk_d;
      else if (wren) mem[w_rd2] <= w_rd1;
      if (pk_reg)        rf[pk_a[2:0]] <= pk_d;
      else if (regwrite) rf[wa] <= wd_sel ? mem_q : alu(w_rd1, w_rd2, mode);
    end
    if (reset)      pc <= 8'h00;
    else if (wr_pc) pc <= w_rd2;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  // ---------------- reference model (instruction level) ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_rf  [8];
  logic [7:0] m_pc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_exec(input logic [7:0] b0, input logic [7:0] b1);
    logic [2:0] op, w, r1, r2;
    op = b0[7:5]; w = b0[4:2]; r1 = b1[7:5]; r2 = b1[4:2];
    m_pc = m_pc + 8'd2;
    case (op)
      3'd0: m_rf[w] = alu(m_rf[r1], m_rf[r2], b0[1:0]);
      3'd1: m_rf[w] = m_mem[m_rf[r2]];
      3'd2: m_mem[m_rf[r2]] = m_rf[r1];
      3'd3: m_pc = m_rf[r2];
      default: ;
    endcase
  endtask

  task automatic poke_mem(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); pk_mem = 1'b1; pk_a = a; pk_d = d;
    @(negedge clk); pk_mem = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk); pk_reg = 1'b1; pk_a = {5'd0, r}; pk_d = d;
    @(negedge clk); pk_reg = 1'b0;
    m_rf[r] = d;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {state, pc_mux, regwrite, wren, wd_sel, pc_inc, wr_pc, halted, instr_done,
                 wa, ra1, ra2, mode}, {3'd0, 1'b1, 18'd0});
  endtask

  task automatic do_reset(input string name);
    @(negedge clk); reset = 1'b1; run = 1'b0;
    #1 check_reset_outputs(name);
    @(negedge clk); reset = 1'b0;
    m_pc = 8'h00;
  endtask

  task automatic stall_check(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); run = 1'b0;
      if (state !== 3'd0 || {regwrite, wren, wr_pc, pc_inc, instr_done} !== 5'd0) bad++;
    end
    check("stall_idle", bad, 0);
  endtask

  // Place one instruction at the model PC, run it, compare schedule and state.
  task automatic exec_one(input logic [7:0] b0, input logic [7:0] b1, input int exp_lat,
                          input bit e_rw, input bit e_wr, input bit e_wp, input bit e_halt,
                          input bit rnd);
    logic [7:0]  a0;
    logic [2:0]  op;
    logic [15:0] k_inc, k_rw, k_wr, k_wp;
    logic [10:0] f_exec;
    int lat, bad, nbad;
    a0 = m_pc; op = b0[7:5];
    k_inc = '0; k_rw = '0; k_wr = '0; k_wp = '0; f_exec = '0;
    lat = 0; bad = 0;
    poke_mem(a0, b0);
    poke_mem(a0 + 8'd1, b1);
    model_exec(b0, b1);
    @(negedge clk); run = 1'b1;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (pc_inc)   k_inc[c] = 1'b1;
      if (regwrite) k_rw[c]  = 1'b1;
      if (wren)     k_wr[c]  = 1'b1;
      if (wr_pc)    k_wp[c]  = 1'b1;
      if (regwrite && wren) bad++;
      if (regwrite && (wd_sel != (op == 3'd1))) bad++;
      if (c <= 4 && !pc_mux) bad++;
      if (((op == 3'd1 && (c == 5 || c == 6)) || (op == 3'd2 && c == 5)) && pc_mux) bad++;
      if (c == 5) f_exec = {wa, mode, ra1, ra2};
      if (instr_done) lat = c;
      if (instr_done) run = 1'b0;
      else if (c > 1) run = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk); run = 1'b0;
    check("latency", lat, exp_lat);
    check("pc_inc_cycles", k_inc, 16'h0014);
    check("regwrite_cycles", k_rw, e_rw ? (32'h1 << exp_lat) : 32'h0);
    check("wren_cycles", k_wr, e_wr ? 32'h20 : 32'h0);
    check("wr_pc_cycles", k_wp, e_wp ? 32'h20 : 32'h0);
    check("ctrl_rules", bad, 0);
    check("exec_fields", f_exec, {b0[4:2], b0[1:0], b1[7:5], b1[4:2]});
    check("state_after", {halted, state}, e_halt ? 4'hF : 4'h0);
    check("pc", pc, m_pc);
    nbad = 0;
    for (int r = 0; r < 8; r++) if (rf[r] !== m_rf[r]) nbad++;
    check("regfile", nbad, 0);
    nbad = 0;
    for (int m = 0; m < 256; m++) if (mem[m] !== m_mem[m]) nbad++;
    check("memory", nbad, 0);
  endtask

  typedef struct {
    logic [7:0] b0, b1;
    logic [2:0] ra; logic [7:0] va;
    logic [2:0] rb; logic [7:0] vb;
    bit         m_en; logic [7:0] m_a, m_v;
    int         lat; bit rw, wr, wp;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int bad;
    logic [2:0] op;
    logic [7:0] b0, b1;

    //            b0           b1           ra    va     rb    vb     m_en m_a    m_v    lat rw wr wp pc
    tbl[0] = '{8'b000_011_01, 8'b001_010_00, 3'd1, 8'h05, 3'd2, 8'h03, 1'b0, 8'h00, 8'h00, 5, 1, 0, 0, 8'h02};
    tbl[1] = '{8'b001_100_00, 8'b000_110_00, 3'd6, 8'h20, 3'd6, 8'h20, 1'b1, 8'h20, 8'hA5, 6, 1, 0, 0, 8'h04};
    tbl[2] = '{8'b010_000_00, 8'b001_010_00, 3'd1, 8'h3C, 3'd2, 8'h40, 1'b0, 8'h00, 8'h00, 5, 0, 1, 0, 8'h06};
    tbl[3] = '{8'b011_000_00, 8'b000_111_00, 3'd7, 8'h10, 3'd7, 8'h10, 1'b0, 8'h00, 8'h00, 5, 0, 0, 1, 8'h10};
    tbl[4] = '{8'b110_000_00, 8'b000_000_00, 3'd0, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 5, 0, 0, 0, 8'h12};

    reset = 1'b1; run = 1'b0;
    rst_h = 1'b1; run_h = 1'b0; mq_h = 8'h00;
    pk_mem = 1'b0; pk_reg = 1'b0; pk_a = 8'h00; pk_d = 8'h00;
    pk_clr = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++)   m_rf[i]  = 8'h00;
    m_pc = 8'h00;
    @(negedge clk); pk_clr = 1'b0;
    check_reset_outputs("reset_state");
    @(negedge clk); reset = 1'b0;

    // run=0 keeps the sequencer parked in FETCH0
    stall_check(5);

    // directed instruction table
    for (int i = 0; i < 5; i++) begin
      set_reg(tbl[i].ra, tbl[i].va);
      set_reg(tbl[i].rb, tbl[i].vb);
      if (tbl[i].m_en) poke_mem(tbl[i].m_a, tbl[i].m_v);
      exec_one(tbl[i].b0, tbl[i].b1, tbl[i].lat, tbl[i].rw, tbl[i].wr, tbl[i].wp, 1'b0, 1'b0);
      check("table_pc", pc, tbl[i].exp_pc);
    end
    check("alu_r3", rf[3], 8'h02);
    check("load_r4", rf[4], 8'hA5);
    check("store_mem40", mem[8'h40], 8'h3C);

    // HALT opcode, then hold for 20 cycles with run toggling
    exec_one(8'b100_000_00, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); run = 1'($urandom_range(0, 1));
      if (!halted || state !== 3'd7 || {regwrite, wren, wr_pc, pc_inc, instr_done} !== 5'd0) bad++;
    end
    check("halt_hold", bad, 0);
    do_reset("reset_from_halt");

    // ILLEGAL_HALT=1 instance: opcode 110 must halt
    @(negedge clk); rst_h = 1'b0; run_h = 1'b1;
    @(negedge clk); run_h = 1'b0; mq_h = 8'b110_000_00;
    check("illegal_latch0", {h_state, h_pc_inc}, {3'd1, 1'b1});
    @(negedge clk); mq_h = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("illegal_exec_done", {h_state, h_instr_done, h_regwrite, h_wren, h_wr_pc}, {3'd4, 4'b1000});
    @(negedge clk); run_h = 1'b1;
    check("illegal_halted", {h_halted, h_state}, 4'hF);
    repeat (3) @(negedge clk);
    check("illegal_halt_hold", {h_halted, h_state, h_instr_done}, 5'b1_111_0);

    // reset asserted during the EXEC cycle of a STORE
    set_reg(3'd1, 8'h77);
    set_reg(3'd2, 8'h50);
    poke_mem(8'h50, 8'h00);
    poke_mem(8'h00, 8'b010_000_00);
    poke_mem(8'h01, 8'b001_010_00);
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (3) @(negedge clk);
    check("store_exec_wren", {state, wren}, {3'd4, 1'b1});
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_in_store");
    @(negedge clk); reset = 1'b0; m_pc = 8'h00;
    @(negedge clk);
    check("store_aborted", mem[8'h50], 8'h00);
    check("pc_after_abort", pc, 8'h00);

    // randomized instruction stream against the model
    for (int r = 0; r < 8; r++) set_reg(3'(r), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 6));
      if (op >= 3'd4) op = op + 3'd1;
      b0 = {op, 5'($urandom)};
      b1 = {6'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) stall_check(int'($urandom_range(1, 3)));
      exec_one(b0, b1, (op == 3'd1) ? 6 : 5, (op <= 3'd1), (op == 3'd2), (op == 3'd3), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
